gfx_scan_timer: RTL
===================

// Module: gfx_scan_timer
// PURPOSE
//  Parametrised pixel-scan timing generator for the graphics pipeline.
//  - Derives pixel-rate steps from the core clock; runs column/row counters over a programmable total raster.
//  - Emits blanking levels/pulses, a linear framebuffer write address/enable and a double-buffer select bit.
//  - Sits between graphics_top (pixel producer) and the double-buffer/VGA path. Also feeds VCOUNT/DISPSTAT MMIO.
// PARAMETERS
//  H_ACTIVE        240  visible pixels per line
//  H_TOTAL         308  pixels per line incl. hblank (> H_ACTIVE)
//  V_ACTIVE        160  visible lines per frame
//  V_TOTAL         228  lines per frame incl. vblank (> V_ACTIVE)
//  DOTS_PER_PIXEL  4    clocks per pixel step (>= 1)
//  Derived localparams: HCNT_W=$clog2(H_TOTAL), VCNT_W=$clog2(V_TOTAL), ADDR_W=$clog2(H_ACTIVE*V_ACTIVE)
// PORTS
//  clock           in   1       core graphics clock
//  reset           in   1       asynchronous, active-high
//  en              in   1       run; low freezes every counter, pulses forced 0
//  sync_clear      in   1       synchronous frame restart
//  pix_step        out  1       high on the clock a pixel step is taken
//  hcount          out  HCNT_W  current column 0..H_TOTAL-1
//  vcount          out  VCNT_W  current line 0..V_TOTAL-1
//  hblank, vblank  out  1       hcount>=H_ACTIVE / vcount>=V_ACTIVE (from registered counters)
//  hblank_start    out  1       1-clock pulse, first clock hcount==H_ACTIVE
//  vblank_start    out  1       1-clock pulse, first clock (vcount==V_ACTIVE, hcount==0)
//  frame_start     out  1       1-clock pulse, first clock (0,0) after a wrap or sync_clear
//  wen             out  1       !hblank && !vblank
//  fb_addr         out  ADDR_W  linear framebuffer address of the current visible pixel
//  buf_sel         out  1       double-buffer select; producer writes buf_sel, display reads ~buf_sel
//  vcount_target   in   VCNT_W  [GFX_SCAN_VMATCH_EN only] line compare value
//  vmatch          out  1       [GFX_SCAN_VMATCH_EN only] level: vcount==vcount_target
//  vmatch_pulse    out  1       [GFX_SCAN_VMATCH_EN only] 1-clock pulse on entry to the matching line
// BEHAVIOUR
//  - Reset: prescaler, hcount, vcount, fb_addr, buf_sel = 0; all pulses 0; pix_step 0; hblank=vblank=0; wen=1.
//  - Prescaler counts 0..DOTS_PER_PIXEL-1. pix_step = en && prescaler==DOTS_PER_PIXEL-1. Prescaler wraps to 0.
//    DOTS_PER_PIXEL==1 -> pix_step=en every clock.
//  - On pix_step:
//    - hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments.
//    - vcount wraps V_TOTAL-1 -> 0 on the same step in which hcount wraps.
//  - fb_addr: increments on pix_step when wen=1.
//    - Holds during blanking. Reaches H_ACTIVE*V_ACTIVE-1 at the last visible pixel.
//    - Cleared to 0 on the step that wraps the frame.
//  - buf_sel toggles exactly once per frame, registered on the step that enters vblank (vcount V_ACTIVE-1 -> V_ACTIVE).
//  - Pulses are registered. Each is high for exactly one clock, the first clock the new counter value is visible.
//    They never repeat during the DOTS_PER_PIXEL-1 hold clocks.
//  - en=0: all state holds (incl. prescaler). Levels keep reflecting held counters. Pulses and pix_step are 0.
//    Resuming continues the sequence with no skipped or repeated step.
//  - sync_clear=1: next clock prescaler, hcount, vcount, fb_addr = 0; buf_sel unchanged; frame_start=1 that clock.
//    Overrides a simultaneous pix_step and acts even when en=0.
//  - Latency: counters update the clock after pix_step. Levels are combinational from registers (0 extra).
//  - Reset asserted mid-frame: immediate return to reset values; first step DOTS_PER_PIXEL clocks after release.
// CONFIGURATION
//  - `GFX_SCAN_VMATCH_EN defined: vcount_target, vmatch and vmatch_pulse exist.
//    - vmatch_pulse fires with the step that makes vcount==vcount_target (hcount becomes 0).
//    - Target >= V_TOTAL never matches. Target changed while already equal: vmatch rises, no pulse.
//  - Not defined: these three ports and their logic are absent; all other behaviour identical.
// STRUCTURE
//  - Package gfx_scan_pkg:
//    - Default raster constants (GBA_H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL/DOTS).
//    - Typedefs hcount_t, vcount_t, fb_addr_t.
//  - Sub-module gfx_wrap_counter #(WIDTH, MAX): en/clear/last wrap counter.
//    Used for the prescaler, column and row counters. Priority: clear > ~en hold > wrap > increment.
// TESTING
//  1. Release reset, en=1, defaults: first pix_step at clock 4 -> hcount=1 at clock 5; wen=1, fb_addr=1.
//  2. Run 1232 clocks: hcount=0, vcount=1; hblank_start high exactly 1 clock at hcount=240; fb_addr=240.
//  3. Run 280896 clocks (one frame): fb_addr peaks 38399; buf_sel 0->1 at vcount=160 with vblank_start;
//     frame_start once; end state (0,0).
//  4. en=0 for 50 clocks at hcount=100: hcount/prescaler hold, no pulses; resume -> hcount=101 after remaining dots.
//  5. sync_clear coincident with pix_step at (239,159): next clock all counters 0, frame_start=1, buf_sel unchanged.
//  6. VMATCH_EN, vcount_target=100: vmatch_pulse once per frame at (0,100), vmatch high 1232 clocks; target=250 -> never.

Source files
------------

// File: rtl/gfx_scan_pkg.sv
// gfx_scan_pkg: default raster constants and counter typedefs
// shared by the scan timer and its counters.
package gfx_scan_pkg;

  localparam int GBA_H_ACTIVE = 240;
  localparam int GBA_H_TOTAL  = 308;
  localparam int GBA_V_ACTIVE = 160;
  localparam int GBA_V_TOTAL  = 228;
  localparam int GBA_DOTS     = 4;

  localparam int GBA_HCNT_W = $clog2(GBA_H_TOTAL);
  localparam int GBA_VCNT_W = $clog2(GBA_V_TOTAL);
  localparam int GBA_ADDR_W = $clog2(GBA_H_ACTIVE * GBA_V_ACTIVE);

  typedef logic [GBA_HCNT_W-1:0] hcount_t;
  typedef logic [GBA_VCNT_W-1:0] vcount_t;
  typedef logic [GBA_ADDR_W-1:0] fb_addr_t;

endpackage

// File: rtl/gfx_wrap_counter.sv
// gfx_wrap_counter: 0..MAX counter with sync clear and enable.
// Priority: clear > hold (~en) > wrap at MAX > increment.
module gfx_wrap_counter
  import gfx_scan_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             last;

  assign last    = (count_q == WIDTH'(MAX));
  assign count_o = count_q;

  // next count with clear/hold/wrap priority
  always_comb begin
    count_d = count_q;
    if (clear_i)      count_d = '0;
    else if (!en_i)   count_d = count_q;
    else if (last)    count_d = '0;
    else              count_d = count_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/gfx_scan_timer.sv
// gfx_scan_timer: pixel-scan timing, blanking, fb address, buffer select.
// Optional line compare enabled by defining GFX_SCAN_VMATCH_EN.
module gfx_scan_timer
  import gfx_scan_pkg::*;
#(
  parameter  int H_ACTIVE       = GBA_H_ACTIVE,
  parameter  int H_TOTAL        = GBA_H_TOTAL,
  parameter  int V_ACTIVE       = GBA_V_ACTIVE,
  parameter  int V_TOTAL        = GBA_V_TOTAL,
  parameter  int DOTS_PER_PIXEL = GBA_DOTS,
  localparam int HCNT_W = $clog2(H_TOTAL),
  localparam int VCNT_W = $clog2(V_TOTAL),
  localparam int ADDR_W = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_clear,
  output logic              pix_step,
  output logic [HCNT_W-1:0] hcount,
  output logic [VCNT_W-1:0] vcount,
  output logic              hblank,
  output logic              vblank,
  output logic              hblank_start,
  output logic              vblank_start,
  output logic              frame_start,
  output logic              wen,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              buf_sel
`ifdef GFX_SCAN_VMATCH_EN
  ,
  input  logic [VCNT_W-1:0] vcount_target,
  output logic              vmatch,
  output logic              vmatch_pulse
`endif
);

  localparam int PRE_W = (DOTS_PER_PIXEL > 1) ? $clog2(DOTS_PER_PIXEL) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic             h_last;
  logic             v_last;
  logic             line_wrap;
  logic             frame_wrap;
  logic             last_vis;
  logic             vbl_entry;

  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              buf_sel_q, buf_sel_d;
  logic              hbs_q, hbs_d;
  logic              vbs_q, vbs_d;
  logic              fs_q, fs_d;

  gfx_wrap_counter #(.WIDTH(PRE_W), .MAX(DOTS_PER_PIXEL - 1)) u_pre (
    .clk_i   (clock),
    .rst_i   (reset),
    .en_i    (en),
    .clear_i (sync_clear),
    .count_o (pre_cnt)
  );

  gfx_wrap_counter #(.WIDTH(HCNT_W), .MAX(H_TOTAL - 1)) u_hcnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .en_i    (pix_step),
    .clear_i (sync_clear),
    .count_o (hcount)
  );

  gfx_wrap_counter #(.WIDTH(VCNT_W), .MAX(V_TOTAL - 1)) u_vcnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .en_i    (line_wrap),
    .clear_i (sync_clear),
    .count_o (vcount)
  );

  assign pix_step   = en && (pre_cnt == PRE_W'(DOTS_PER_PIXEL - 1));
  assign h_last     = (hcount == HCNT_W'(H_TOTAL - 1));
  assign v_last     = (vcount == VCNT_W'(V_TOTAL - 1));
  assign line_wrap  = pix_step && h_last;
  assign frame_wrap = line_wrap && v_last;
  assign vbl_entry  = line_wrap && (vcount == VCNT_W'(V_ACTIVE - 1));
  assign last_vis   = (hcount == HCNT_W'(H_ACTIVE - 1)) &&
                      (vcount == VCNT_W'(V_ACTIVE - 1));

  assign hblank       = (hcount >= HCNT_W'(H_ACTIVE));
  assign vblank       = (vcount >= VCNT_W'(V_ACTIVE));
  assign wen          = !hblank && !vblank;
  assign fb_addr      = fb_addr_q;
  assign buf_sel      = buf_sel_q;
  assign hblank_start = hbs_q;
  assign vblank_start = vbs_q;
  assign frame_start  = fs_q;

  // address, buffer select and registered pulses; the last visible
  // pixel does not advance so the address peaks at the final pixel
  always_comb begin
    fb_addr_d = fb_addr_q;
    buf_sel_d = buf_sel_q;
    hbs_d     = 1'b0;
    vbs_d     = 1'b0;
    fs_d      = 1'b0;
    if (sync_clear) begin
      fb_addr_d = '0;
      fs_d      = 1'b1;
    end else if (pix_step) begin
      if (frame_wrap)            fb_addr_d = '0;
      else if (wen && !last_vis) fb_addr_d = fb_addr_q + 1'b1;
      if (vbl_entry) buf_sel_d = ~buf_sel_q;
      hbs_d = (hcount == HCNT_W'(H_ACTIVE - 1));
      vbs_d = vbl_entry;
      fs_d  = frame_wrap;
    end
  end

  // state and pulse registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_addr_q <= '0;
      buf_sel_q <= 1'b0;
      hbs_q     <= 1'b0;
      vbs_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      fb_addr_q <= fb_addr_d;
      buf_sel_q <= buf_sel_d;
      hbs_q     <= hbs_d;
      vbs_q     <= vbs_d;
      fs_q      <= fs_d;
    end
  end

`ifdef GFX_SCAN_VMATCH_EN
  logic [VCNT_W-1:0] v_next;
  logic              vmp_q, vmp_d;

  assign v_next       = v_last ? '0 : vcount + 1'b1;
  assign vmatch       = (vcount == vcount_target);
  assign vmatch_pulse = vmp_q;

  // pulse only on the step that moves onto the target line
  always_comb begin
    vmp_d = 1'b0;
    if (!sync_clear && line_wrap)
      vmp_d = (v_next == vcount_target);
  end

  // match pulse register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vmp_q <= 1'b0;
    else       vmp_q <= vmp_d;
  end
`endif

endmodule
